// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared sequencer state encodings and small decode helpers for the hazard controller.
package pipe_hazard_ctrl_pkg;

    typedef logic [1:0] ctrl_state_t;

    localparam ctrl_state_t CTRL_RUN      = 2'd0;
    localparam ctrl_state_t CTRL_MEM_WAIT = 2'd1;
    localparam ctrl_state_t CTRL_REDIRECT = 2'd2;

    // True when a used source register names the destination of the load in EX.
    function automatic logic src_match(input logic used, input logic [4:0] rs,
                                       input logic [4:0] rd);
        return used && (rs == rd);
    endfunction

endpackage

// File: rtl/pipe_stall_cnt.sv
// Free-running enable counter used as the stall-cycle performance counter; wraps silently.
module pipe_stall_cnt #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    // Count one per enabled cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: turns load-use, redirect and slow-memory hazards into per-stage
// hold/flush controls and a PC redirect, and counts cycles in which the PC is held.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REDIRECT_CYC = 1,
    parameter int unsigned MEM_TIMEOUT  = 255,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1_addr,
    input  logic [4:0]       id_rs2_addr,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic             ex_mem_re,
    input  logic [4:0]       ex_rd_addr,
    input  logic             ex_jump_en,
    input  logic [31:0]      ex_jump_addr,
    input  logic             dmem_req,
    input  logic             dmem_ack,
    output logic             hold_pc,
    output logic             hold_if_id,
    output logic             hold_id_ex,
    output logic             hold_ex_mem,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             flush_mem_wb,
    output logic             jump_en_o,
    output logic [31:0]      jump_addr_o,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

    ctrl_state_t       state_q, state_d;
    logic [1:0]        rcnt_q, rcnt_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              mem_err_q, mem_err_d;

    logic mem_stall, jump_take, load_use, wait_last;

    // Hazard detection in priority order. The cycle after a timeout (mem_err high) never
    // stalls, so the abandoned access can leave MEM.
    always_comb begin
        mem_stall = !mem_err_q && !dmem_ack && (dmem_req || (state_q == CTRL_MEM_WAIT));
        jump_take = ex_jump_en && !mem_stall;
        load_use  = !mem_stall && !jump_take && ex_mem_re && (ex_rd_addr != 5'd0) &&
                    (src_match(id_rs1_used, id_rs1_addr, ex_rd_addr) ||
                     src_match(id_rs2_used, id_rs2_addr, ex_rd_addr));
        wait_last = (MEM_TIMEOUT != 0) && (32'(wait_q) == MEM_TIMEOUT - 1);
    end

    // Stage controls; a load-use in a redirect tail holds IF/ID instead of flushing it and
    // postpones that bubble by one cycle.
    always_comb begin
        hold_pc      = 1'b0;
        hold_if_id   = 1'b0;
        hold_id_ex   = 1'b0;
        hold_ex_mem  = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        flush_mem_wb = 1'b0;
        jump_en_o    = 1'b0;
        jump_addr_o  = 32'd0;
        if (!rst) begin
            jump_addr_o = ex_jump_addr;
            if (mem_stall) begin
                hold_pc      = 1'b1;
                hold_if_id   = 1'b1;
                hold_id_ex   = 1'b1;
                hold_ex_mem  = 1'b1;
                flush_mem_wb = 1'b1;
            end else if (jump_take) begin
                jump_en_o   = 1'b1;
                flush_if_id = 1'b1;
                flush_id_ex = 1'b1;
            end else if (load_use) begin
                hold_pc     = 1'b1;
                hold_if_id  = 1'b1;
                flush_id_ex = 1'b1;
            end else if (rcnt_q != 2'd0) begin
                flush_if_id = 1'b1;
            end
        end
    end

    // Next-state: the redirect counter is frozen across a memory stall so the remaining
    // IF/ID bubbles are still issued once memory releases.
    always_comb begin
        state_d   = state_q;
        rcnt_d    = rcnt_q;
        wait_d    = wait_q;
        mem_err_d = 1'b0;
        if (mem_stall) begin
            state_d = CTRL_MEM_WAIT;
            if (state_q != CTRL_MEM_WAIT) begin
                wait_d = '0;
            end else if (MEM_TIMEOUT != 0) begin
                if (wait_last) begin
                    state_d   = (rcnt_q != 2'd0) ? CTRL_REDIRECT : CTRL_RUN;
                    wait_d    = '0;
                    mem_err_d = 1'b1;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
        end else begin
            wait_d = '0;
            if (jump_take) begin
                rcnt_d  = 2'(REDIRECT_CYC);
                state_d = (REDIRECT_CYC != 0) ? CTRL_REDIRECT : CTRL_RUN;
            end else if (load_use) begin
                state_d = (rcnt_q != 2'd0) ? CTRL_REDIRECT : CTRL_RUN;
            end else if (rcnt_q != 2'd0) begin
                rcnt_d  = rcnt_q - 2'd1;
                state_d = (rcnt_q == 2'd1) ? CTRL_RUN : CTRL_REDIRECT;
            end else begin
                state_d = CTRL_RUN;
            end
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= CTRL_RUN;
            rcnt_q    <= 2'd0;
            wait_q    <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rcnt_q    <= rcnt_d;
            wait_q    <= wait_d;
            mem_err_q <= mem_err_d;
        end
    end

    assign mem_err = mem_err_q;

    pipe_stall_cnt #(
        .CNT_W(CNT_W)
    ) u_stall_cnt (
        .clk(clk),
        .rst(rst),
        .en (hold_pc),
        .cnt(stall_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed and randomized bench for pipe_hazard_ctrl against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int RC = 1;
    localparam int TO = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    id_rs1_addr, id_rs2_addr, ex_rd_addr;
    logic          id_rs1_used, id_rs2_used, ex_mem_re, ex_jump_en, dmem_req, dmem_ack;
    logic [31:0]   ex_jump_addr;
    logic          hold_pc, hold_if_id, hold_id_ex, hold_ex_mem;
    logic          flush_if_id, flush_id_ex, flush_mem_wb, jump_en_o, mem_err;
    logic [31:0]   jump_addr_o;
    logic [CW-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    // Model state: waiting on memory, wait cycles so far, redirect bubbles left, error pulse.
    bit m_waiting;
    int m_wait_n;
    int m_redir;
    bit m_err;
    int m_cnt;
    bit e_stall, e_jump, e_lu, e_tail;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .REDIRECT_CYC(RC),
        .MEM_TIMEOUT (TO),
        .CNT_W       (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .id_rs1_addr (id_rs1_addr),
        .id_rs2_addr (id_rs2_addr),
        .id_rs1_used (id_rs1_used),
        .id_rs2_used (id_rs2_used),
        .ex_mem_re   (ex_mem_re),
        .ex_rd_addr  (ex_rd_addr),
        .ex_jump_en  (ex_jump_en),
        .ex_jump_addr(ex_jump_addr),
        .dmem_req    (dmem_req),
        .dmem_ack    (dmem_ack),
        .hold_pc     (hold_pc),
        .hold_if_id  (hold_if_id),
        .hold_id_ex  (hold_id_ex),
        .hold_ex_mem (hold_ex_mem),
        .flush_if_id (flush_if_id),
        .flush_id_ex (flush_id_ex),
        .flush_mem_wb(flush_mem_wb),
        .jump_en_o   (jump_en_o),
        .jump_addr_o (jump_addr_o),
        .mem_err     (mem_err),
        .stall_cnt   (stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        id_rs1_addr = 5'd0; id_rs2_addr = 5'd0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
        ex_mem_re = 1'b0; ex_rd_addr = 5'd0; ex_jump_en = 1'b0; ex_jump_addr = 32'd0;
        dmem_req = 1'b0; dmem_ack = 1'b0;
    endtask

    task automatic model_reset();
        m_waiting = 0; m_wait_n = 0; m_redir = 0; m_err = 0; m_cnt = 0;
    endtask

    task automatic model_eval();
        e_stall = !m_err && !dmem_ack && (dmem_req || m_waiting);
        e_jump  = ex_jump_en && !e_stall;
        e_lu    = !e_stall && !e_jump && ex_mem_re && (ex_rd_addr != 0) &&
                  ((id_rs1_used && id_rs1_addr == ex_rd_addr) ||
                   (id_rs2_used && id_rs2_addr == ex_rd_addr));
        e_tail  = !e_stall && !e_jump && !e_lu && (m_redir > 0);
    endtask

    task automatic model_tick();
        if (e_stall || e_lu) m_cnt = (m_cnt + 1) % (1 << CW);
        m_err = 0;
        if (e_stall) begin
            if (m_waiting) begin
                m_wait_n++;
                if (m_wait_n == TO) begin
                    m_waiting = 0; m_wait_n = 0; m_err = 1;
                end
            end else begin
                m_waiting = 1; m_wait_n = 0;
            end
        end else begin
            m_waiting = 0; m_wait_n = 0;
            if (e_jump) m_redir = RC;
            else if (e_tail) m_redir--;
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "/hold_pc"},      32'(hold_pc),      32'(e_stall || e_lu));
        chk({tag, "/hold_if_id"},   32'(hold_if_id),   32'(e_stall || e_lu));
        chk({tag, "/hold_id_ex"},   32'(hold_id_ex),   32'(e_stall));
        chk({tag, "/hold_ex_mem"},  32'(hold_ex_mem),  32'(e_stall));
        chk({tag, "/flush_if_id"},  32'(flush_if_id),  32'(e_jump || e_tail));
        chk({tag, "/flush_id_ex"},  32'(flush_id_ex),  32'(e_jump || e_lu));
        chk({tag, "/flush_mem_wb"}, 32'(flush_mem_wb), 32'(e_stall));
        chk({tag, "/jump_en_o"},    32'(jump_en_o),    32'(e_jump));
        chk({tag, "/jump_addr_o"},  jump_addr_o,       ex_jump_addr);
        chk({tag, "/mem_err"},      32'(mem_err),      32'(m_err));
        chk({tag, "/stall_cnt"},    32'(stall_cnt),    32'(m_cnt));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "/hold_pc"},      32'(hold_pc),      32'd0);
        chk({tag, "/hold_if_id"},   32'(hold_if_id),   32'd0);
        chk({tag, "/hold_id_ex"},   32'(hold_id_ex),   32'd0);
        chk({tag, "/hold_ex_mem"},  32'(hold_ex_mem),  32'd0);
        chk({tag, "/flush_if_id"},  32'(flush_if_id),  32'd0);
        chk({tag, "/flush_id_ex"},  32'(flush_id_ex),  32'd0);
        chk({tag, "/flush_mem_wb"}, 32'(flush_mem_wb), 32'd0);
        chk({tag, "/jump_en_o"},    32'(jump_en_o),    32'd0);
        chk({tag, "/jump_addr_o"},  jump_addr_o,       32'd0);
        chk({tag, "/mem_err"},      32'(mem_err),      32'd0);
        chk({tag, "/stall_cnt"},    32'(stall_cnt),    32'd0);
    endtask

    // Inputs are set at posedge+1; outputs are compared at posedge+2.
    task automatic eval_cycle(input string tag);
        #1;
        model_eval();
        check_outputs(tag);
    endtask

    task automatic tick();
        @(posedge clk);
        model_tick();
        #1;
    endtask

    // Asynchronous reset pulse raised between edges; outputs must drop at once.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        check_zero(tag);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        idle();
        rst = 1'b1;
        #2;
        check_zero("por");
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        // 1: reset in the middle of a memory stall
        dmem_req = 1'b1;
        eval_cycle("t1_s0"); tick();
        eval_cycle("t1_s1"); tick();
        do_reset("t1_rst");
        idle();
        eval_cycle("t1_after");
        chk("t1_run_no_hold", 32'(hold_pc), 32'd0);
        chk("t1_cnt_zero", 32'(stall_cnt), 32'd0);
        tick();

        // 2: load-use on rs2, then the same with rd = x0
        ex_mem_re = 1'b1; ex_rd_addr = 5'd5; id_rs2_addr = 5'd5; id_rs2_used = 1'b1;
        eval_cycle("t2_lu");
        chk("t2_hold_pc", 32'(hold_pc), 32'd1);
        chk("t2_flush_id_ex", 32'(flush_id_ex), 32'd1);
        tick();
        ex_mem_re = 1'b0;
        eval_cycle("t2_next");
        chk("t2_one_cycle", 32'(hold_pc), 32'd0);
        chk("t2_cnt", 32'(stall_cnt), 32'd1);
        tick();
        ex_mem_re = 1'b1; ex_rd_addr = 5'd0; id_rs2_addr = 5'd0;
        eval_cycle("t2_x0");
        chk("t2_x0_no_hold", 32'(hold_pc), 32'd0);
        tick();
        idle();

        // 3: taken jump with one extra IF/ID bubble
        ex_jump_en = 1'b1; ex_jump_addr = 32'h0000_0100;
        eval_cycle("t3_c0");
        chk("t3_c0_jump", 32'(jump_en_o), 32'd1);
        chk("t3_c0_addr", jump_addr_o, 32'h0000_0100);
        chk("t3_c0_fid", 32'(flush_if_id), 32'd1);
        chk("t3_c0_fex", 32'(flush_id_ex), 32'd1);
        tick();
        ex_jump_en = 1'b0;
        eval_cycle("t3_c1");
        chk("t3_c1_fid", 32'(flush_if_id), 32'd1);
        chk("t3_c1_fex", 32'(flush_id_ex), 32'd0);
        tick();
        eval_cycle("t3_c2");
        chk("t3_c2_fid", 32'(flush_if_id), 32'd0);
        tick();

        // 4: slow memory acked after three stalled cycles
        do_reset("t4_rst");
        idle();
        dmem_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            eval_cycle("t4_wait");
            chk("t4_hold_ex_mem", 32'(hold_ex_mem), 32'd1);
            chk("t4_flush_mem_wb", 32'(flush_mem_wb), 32'd1);
            tick();
        end
        dmem_ack = 1'b1;
        eval_cycle("t4_ack");
        chk("t4_ack_release", 32'(hold_pc), 32'd0);
        tick();
        idle();
        eval_cycle("t4_done");
        chk("t4_cnt", 32'(stall_cnt), 32'd3);
        tick();

        // 5: jump deferred by a memory stall, taken on the ack cycle
        do_reset("t5_rst");
        idle();
        dmem_req = 1'b1; ex_jump_en = 1'b1; ex_jump_addr = 32'h0000_0200;
        for (int i = 0; i < 2; i++) begin
            eval_cycle("t5_wait");
            chk("t5_deferred", 32'(jump_en_o), 32'd0);
            tick();
        end
        dmem_ack = 1'b1;
        eval_cycle("t5_ack");
        chk("t5_taken", 32'(jump_en_o), 32'd1);
        tick();
        idle();
        eval_cycle("t5_tail"); tick();

        // 6: memory never acks; timeout after four MEM_WAIT cycles
        do_reset("t6_rst");
        idle();
        dmem_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            eval_cycle("t6_wait");
            chk("t6_no_err", 32'(mem_err), 32'd0);
            chk("t6_held", 32'(hold_pc), 32'd1);
            tick();
        end
        eval_cycle("t6_err");
        chk("t6_err_pulse", 32'(mem_err), 32'd1);
        chk("t6_released", 32'(hold_pc), 32'd0);
        tick();
        dmem_req = 1'b0;
        eval_cycle("t6_after");
        chk("t6_err_one_cycle", 32'(mem_err), 32'd0);
        tick();

        // Randomized traffic with occasional asynchronous resets
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset("rand_rst");
            end
            id_rs1_addr  = 5'($urandom_range(0, 3));
            id_rs2_addr  = 5'($urandom_range(0, 3));
            ex_rd_addr   = 5'($urandom_range(0, 3));
            id_rs1_used  = 1'($urandom_range(0, 1));
            id_rs2_used  = 1'($urandom_range(0, 1));
            ex_mem_re    = ($urandom_range(0, 9) < 4);
            ex_jump_en   = ($urandom_range(0, 9) < 1);
            ex_jump_addr = $urandom;
            dmem_req     = ($urandom_range(0, 9) < 3);
            dmem_ack     = ($urandom_range(0, 9) < 4);
            eval_cycle("rand");
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
